// File: rtl/iobuf_ctrl_pkg.sv
// iobuf_ctrl_pkg: shared types and constants for the IOBUF direction controller.
//   state_t     : controller FSM states
//   prio_t      : which requester wins when both ask in the same IDLE cycle
//   CNT_W       : width of the turnaround / beat / timeout counters
//   TIMEOUT_CYC : consecutive TX_VALID-low DRIVE cycles that force an abort
//   TA_MIN/MAX  : legal range of the TA_CYC parameter
package iobuf_ctrl_pkg;

    localparam int CNT_W       = 8;
    localparam int TIMEOUT_CYC = 256;
    localparam int TA_MIN      = 1;
    localparam int TA_MAX      = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DRIVE,
        ST_POST,
        ST_SAMPLE
    } state_t;

    typedef enum logic {
        PRIO_RX = 1'b0,
        PRIO_TX = 1'b1
    } prio_t;

    function automatic logic ta_ok(input int ta);
        return (ta >= TA_MIN) && (ta <= TA_MAX);
    endfunction

endpackage

// File: rtl/iobuf_ctrl_cnt.sv
// iobuf_ctrl_cnt: loadable down-counter with a zero flag. Stops at zero
// (never wraps), so a load of N followed by decrements gives N+1 cycles
// until the cycle in which zero is seen.
//   gclk, grst_n : clock, synchronous active-low reset (count -> 0)
//   load         : load load_val (has priority over dec)
//   load_val     : value to load
//   dec          : decrement when non-zero
//   zero         : count == 0
module iobuf_ctrl_cnt
    import iobuf_ctrl_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         gclk,
    input  logic         grst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge gclk) begin
        if (!grst_n)
            cnt_q <= '0;
        else if (load)
            cnt_q <= load_val;
        else if (dec && (cnt_q != '0))
            cnt_q <= cnt_q - W'(1);
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/iobuf_dir_ctrl.sv
// iobuf_dir_ctrl: half-duplex direction controller for a bank of WIDTH IOBUFs.
// Arbitrates the pad bank between a TX requester (drives pads) and an RX
// requester (samples pads) and inserts TA_CYC high-Z cycles before and after
// every drive burst.
//
// Optional feature macro: IOBUF_CTRL_TIMEOUT_EN
//   defined   : 256 consecutive TX_VALID-low cycles in DRIVE end the burst,
//               TX_ABORT pulses in the first POST cycle.
//   undefined : DRIVE waits forever, TX_ABORT is tied 0.
//
// Ports:
//   CLK, RST_N          clock, synchronous active-low reset
//   TX_REQ              drive request (level, held until first TX_READY)
//   TX_VALID/DATA/LAST  TX beat; accepted when TX_VALID & TX_READY
//   TX_READY            high in DRIVE
//   TX_ABORT            one-cycle pulse on timeout abort
//   RX_REQ, RX_LEN      sample request (level) and beats-1, captured at RX_GNT
//   RX_GNT              one-cycle grant pulse
//   RX_VALID, RX_DATA   registered pad samples
//   BUSY                state != IDLE
//   PAD_I, PAD_T, PAD_O IOBUF I, T (1 = high-Z, all bits equal), O
module iobuf_dir_ctrl
    import iobuf_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int TA_CYC = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             TX_REQ,
    input  logic             TX_VALID,
    input  logic [WIDTH-1:0] TX_DATA,
    input  logic             TX_LAST,
    output logic             TX_READY,
    output logic             TX_ABORT,
    input  logic             RX_REQ,
    input  logic [7:0]       RX_LEN,
    output logic             RX_GNT,
    output logic             RX_VALID,
    output logic [WIDTH-1:0] RX_DATA,
    output logic             BUSY,
    output logic [WIDTH-1:0] PAD_I,
    output logic [WIDTH-1:0] PAD_T,
    input  logic [WIDTH-1:0] PAD_O
);

    if (!ta_ok(TA_CYC)) begin : g_ta_bad
        $error("iobuf_dir_ctrl: TA_CYC must be in 1..15");
    end

    state_t             state_q, state_d;
    prio_t              prio_q, prio_d;
    logic               cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0]   cnt_val;
    logic               tx_accept;
    logic               timeout;

    assign tx_accept = TX_READY & TX_VALID;
    assign BUSY      = (state_q != ST_IDLE);

    // One counter serves PRE/POST turnaround and the SAMPLE beat count;
    // these phases never overlap.
    iobuf_ctrl_cnt #(.W(CNT_W)) u_cnt (
        .gclk     (CLK),
        .grst_n   (RST_N),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

`ifdef IOBUF_CTRL_TIMEOUT_EN
    logic to_load, to_zero, abort_q;

    // Reloaded outside DRIVE and on every valid cycle, so in DRIVE it counts
    // the current run of TX_VALID-low cycles; zero marks the 256th.
    assign to_load = (state_q != ST_DRIVE) | TX_VALID;
    assign timeout = (state_q == ST_DRIVE) & ~TX_VALID & to_zero;

    iobuf_ctrl_cnt #(.W(CNT_W)) u_to_cnt (
        .gclk     (CLK),
        .grst_n   (RST_N),
        .load     (to_load),
        .load_val (CNT_W'(TIMEOUT_CYC - 1)),
        .dec      (~to_load),
        .zero     (to_zero)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N)
            abort_q <= 1'b0;
        else
            abort_q <= timeout;
    end

    assign TX_ABORT = abort_q;
`else
    assign timeout  = 1'b0;
    assign TX_ABORT = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            prio_q  <= PRIO_RX;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
        end
    end

    // Priority moves to the side that was not just granted (round-robin).
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_dec  = 1'b0;
        TX_READY = 1'b0;
        RX_GNT   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (TX_REQ && (!RX_REQ || (prio_q == PRIO_TX))) begin
                    state_d  = ST_PRE;
                    prio_d   = PRIO_RX;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TA_CYC - 1);
                end else if (RX_REQ) begin
                    RX_GNT   = 1'b1;
                    state_d  = ST_SAMPLE;
                    prio_d   = PRIO_TX;
                    cnt_load = 1'b1;
                    cnt_val  = RX_LEN;
                end
            end
            ST_PRE: begin
                if (cnt_zero) state_d = ST_DRIVE;
                else          cnt_dec = 1'b1;
            end
            ST_DRIVE: begin
                TX_READY = 1'b1;
                if ((TX_VALID && TX_LAST) || timeout) begin
                    // TA_CYC+1 POST cycles: one still driving, TA_CYC high-Z.
                    state_d  = ST_POST;
                    cnt_load = 1'b1;
                    cnt_val  = CNT_W'(TA_CYC);
                end
            end
            ST_POST, ST_SAMPLE: begin
                if (cnt_zero) state_d = ST_IDLE;
                else          cnt_dec = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pad drive: PAD_T drops only on an accepted beat, holds through
    // TX_VALID gaps in DRIVE, and returns high the cycle after DRIVE ends,
    // which leaves the last beat on the pads for the first POST cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            PAD_I    <= '0;
            PAD_T    <= '1;
            RX_DATA  <= '0;
            RX_VALID <= 1'b0;
        end else begin
            if (tx_accept) begin
                PAD_I <= TX_DATA;
                PAD_T <= '0;
            end else if (state_q != ST_DRIVE) begin
                PAD_T <= '1;
            end
            RX_VALID <= (state_q == ST_SAMPLE);
            if (state_q == ST_SAMPLE)
                RX_DATA <= PAD_O;
        end
    end

endmodule

// File: tb/tb_iobuf_dir_ctrl.sv
// tb_iobuf_dir_ctrl: randomized self-checking bench for iobuf_dir_ctrl.
// Each transaction is scripted from the timing rules (grant, TA_CYC
// turnaround, beats, POST, sample window); every cycle all outputs are
// compared to the expectation of that script.
module tb_iobuf_dir_ctrl;

    localparam int WIDTH = 8;
    localparam int TA    = 2;

    logic             CLK = 1'b0;
    logic             RST_N;
    logic             TX_REQ, TX_VALID, TX_LAST, TX_READY, TX_ABORT;
    logic [WIDTH-1:0] TX_DATA;
    logic             RX_REQ, RX_GNT, RX_VALID, BUSY;
    logic [7:0]       RX_LEN;
    logic [WIDTH-1:0] RX_DATA, PAD_I, PAD_T, PAD_O;

    always #5 CLK = ~CLK;

    iobuf_dir_ctrl #(.WIDTH(WIDTH), .TA_CYC(TA)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .TX_REQ(TX_REQ), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA), .TX_LAST(TX_LAST),
        .TX_READY(TX_READY), .TX_ABORT(TX_ABORT),
        .RX_REQ(RX_REQ), .RX_LEN(RX_LEN), .RX_GNT(RX_GNT),
        .RX_VALID(RX_VALID), .RX_DATA(RX_DATA), .BUSY(BUSY),
        .PAD_I(PAD_I), .PAD_T(PAD_T), .PAD_O(PAD_O)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // reference state
    logic [WIDTH-1:0] m_pad_i, m_rx_data, pend_d;
    bit               pend_v;     // a sample was taken last cycle
    bit               m_pad_t;
    bit               m_rx_pri;   // 1: RX wins a simultaneous request
    logic [WIDTH-1:0] tx_beats[$];
    int               tx_gaps[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pad_i   = '0;
        m_rx_data = '0;
        pend_v    = 1'b0;
        pend_d    = '0;
        m_pad_t   = 1'b1;
        m_rx_pri  = 1'b1;
    endtask

    // Check the current cycle (inputs already applied), then advance.
    task automatic cycle(input bit e_busy, input bit e_txr, input bit e_gnt,
                         input bit e_padt, input bit e_smp, input bit e_abort);
        #1;
        chk("busy",     BUSY,     e_busy);
        chk("tx_ready", TX_READY, e_txr);
        chk("rx_gnt",   RX_GNT,   e_gnt);
        chk("pad_t",    PAD_T,    {WIDTH{e_padt}});
        chk("pad_i",    PAD_I,    m_pad_i);
        chk("rx_valid", RX_VALID, pend_v);
        if (pend_v) m_rx_data = pend_d;
        chk("rx_data",  RX_DATA,  m_rx_data);
        chk("tx_abort", TX_ABORT, e_abort);
        pend_v = e_smp;
        pend_d = PAD_O;
        @(posedge CLK);
        #1;
        PAD_O = WIDTH'($urandom);
    endtask

    task automatic idle(input int n);
        TX_REQ = 0; RX_REQ = 0; TX_VALID = 0; TX_LAST = 0;
        repeat (n) cycle(0, 0, 0, 1, 0, 0);
    endtask

    // grant cycle, then RX_LEN+1 sample cycles; RX_LEN is scrambled after grant
    task automatic run_rx(input int len, input bit ramp, input logic [WIDTH-1:0] base);
        RX_REQ = 1; RX_LEN = 8'(len);
        cycle(0, 0, 1, 1, 0, 0);
        RX_REQ = 0;
        m_rx_pri = 1'b0;
        for (int i = 0; i <= len; i++) begin
            RX_LEN = 8'($urandom);
            if (ramp) PAD_O = WIDTH'(base + i);
            cycle(1, 0, 0, 1, 1, 0);
        end
    endtask

    // grant cycle plus TA high-Z PRE cycles
    task automatic tx_open();
        TX_REQ = 1; TX_VALID = 1'($urandom); TX_LAST = 1'($urandom); TX_DATA = WIDTH'($urandom);
        cycle(0, 0, 0, 1, 0, 0);
        m_rx_pri = 1'b1;
        repeat (TA) begin
            TX_VALID = 1'($urandom);
            cycle(1, 0, 0, 1, 0, 0);
        end
    endtask

    task automatic tx_drive(input bit with_last);
        int n;
        n = tx_beats.size();
        for (int j = 0; j < n; j++) begin
            repeat (tx_gaps[j]) begin
                TX_VALID = 0; TX_DATA = WIDTH'($urandom); TX_LAST = 1'($urandom);
                cycle(1, 1, 0, m_pad_t, 0, 0);
                TX_REQ = 0;
            end
            TX_VALID = 1; TX_DATA = tx_beats[j]; TX_LAST = with_last && (j == n - 1);
            cycle(1, 1, 0, m_pad_t, 0, 0);
            TX_REQ = 0;
            m_pad_i = tx_beats[j];
            m_pad_t = 1'b0;
        end
        TX_VALID = 0; TX_LAST = 0;
    endtask

    // first POST cycle still drives, then TA high-Z cycles
    task automatic tx_close(input bit abort);
        TX_VALID = 1'($urandom);
        cycle(1, 0, 0, m_pad_t, 0, abort);
        m_pad_t = 1'b1;
        repeat (TA) begin
            TX_VALID = 1'($urandom);
            cycle(1, 0, 0, 1, 0, 0);
        end
        TX_VALID = 0;
    endtask

    task automatic mk_tx(input int n);
        tx_beats.delete(); tx_gaps.delete();
        for (int i = 0; i < n; i++) begin
            tx_beats.push_back(WIDTH'($urandom));
            tx_gaps.push_back(($urandom % 4 == 0) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic tx_all();
        tx_open(); tx_drive(1); tx_close(0);
    endtask

    // kind 0: TX only, 1: RX only, 2: both in the same cycle
    task automatic episode(input int kind, input int len);
        case (kind)
            0: begin mk_tx($urandom_range(1, 4)); tx_all(); end
            1: run_rx(len, 0, '0);
            default: begin
                mk_tx($urandom_range(1, 4));
                TX_REQ = 1; RX_REQ = 1; RX_LEN = 8'(len);
                if (m_rx_pri) begin run_rx(len, 0, '0); tx_all(); end
                else          begin tx_all(); run_rx(len, 0, '0); end
            end
        endcase
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 0; TX_REQ = 0; TX_VALID = 0; TX_LAST = 0; TX_DATA = '0;
        RX_REQ = 0; RX_LEN = '0; PAD_O = '0;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RST_N = 1;
        cycle(0, 0, 0, 1, 0, 0);          // reset state

        // contention from reset: RX first, TX second
        episode(2, 1);
        // RX ramp, RX_LEN=3
        run_rx(3, 1, 8'h10);
        // second pair: priority now with TX, so RX goes second
        episode(2, 2);
        idle(2);

        // TX A5, 5A
        tx_beats = '{8'hA5, 8'h5A}; tx_gaps = '{0, 0};
        tx_all();
        idle(1);

        // TX with a 3-cycle valid gap mid-burst
        mk_tx(3); tx_gaps = '{0, 3, 0};
        tx_all();

        // RX length boundaries, back to back
        run_rx(0, 0, '0);
        run_rx(255, 1, 8'h00);
        idle(1);

        repeat (40) begin
            int kind, len;
            kind = $urandom_range(0, 2);
            len  = ($urandom % 8 == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 5));
            episode(kind, len);
            if ($urandom % 2 == 1) idle($urandom_range(1, 3));
        end

        // TX_VALID stall in DRIVE after one beat
        mk_tx(1); tx_gaps = '{0};
        tx_open(); tx_drive(0);
`ifdef IOBUF_CTRL_TIMEOUT_EN
        repeat (256) begin TX_VALID = 0; cycle(1, 1, 0, m_pad_t, 0, 0); end
        tx_close(1);
`else
        repeat (1000) begin TX_VALID = 0; cycle(1, 1, 0, m_pad_t, 0, 0); end
        mk_tx(1); tx_gaps = '{0};
        tx_drive(1); tx_close(0);
`endif
        idle(2);

        // reset in DRIVE mid-burst
        mk_tx(2);
        tx_open(); tx_drive(0);
        TX_VALID = 0; RST_N = 0;
        cycle(1, 1, 0, m_pad_t, 0, 0);
        RST_N = 1;
        model_reset();
        cycle(0, 0, 0, 1, 0, 0);
        // priority back to RX after reset
        episode(2, 0);
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
